// File: rtl/debouncing_pkg.sv
// Shared types and constants for the three-tick switch debouncer.
package debouncing_pkg;

    // Number of consecutive sample ticks the input must hold its new level.
    localparam int unsigned DB_WAIT_TICKS = 3;

    // Debouncer states. The low-level half and the high-level half are
    // grouped so the MSB alone tells which settled level is being reported.
    typedef enum logic [2:0] {
        ZERO    = 3'd0,
        WAIT1_1 = 3'd1,
        WAIT1_2 = 3'd2,
        WAIT1_3 = 3'd3,
        ONE     = 3'd4,
        WAIT0_1 = 3'd5,
        WAIT0_2 = 3'd6,
        WAIT0_3 = 3'd7
    } state_t;

    // Debounced level reported while sitting in a given state.
    function automatic logic db_level(input state_t s);
        logic lvl;
        case (s)
            ONE, WAIT0_1, WAIT0_2, WAIT0_3: lvl = 1'b1;
            default:                        lvl = 1'b0;
        endcase
        return lvl;
    endfunction

endpackage

// File: rtl/debouncing_circuito.sv
// Moore-FSM switch debouncer: db_o follows sw_i only after sw_i has held
// its new level for three consecutive m_tick_i samples.
// Optional rising-edge pulse output db_tick_o enabled by DEBOUNCE_EDGE_TICK_EN.
module debouncing_circuito
    import debouncing_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic sw_i,
    input  logic m_tick_i,
    output logic db_o
`ifdef DEBOUNCE_EDGE_TICK_EN
    ,
    output logic db_tick_o
`endif
);

    state_t state_q;
    state_t state_d;
    state_t state;
    logic   db_q;
    logic   db_d;

    // Named view of the state register for observation.
    assign state = state_q;

    // Next-state logic; a bounce back to the old level wins over a tick.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ZERO: begin
                if (sw_i) state_d = WAIT1_1;
            end
            WAIT1_1: begin
                if (!sw_i)        state_d = ZERO;
                else if (m_tick_i) state_d = WAIT1_2;
            end
            WAIT1_2: begin
                if (!sw_i)        state_d = ZERO;
                else if (m_tick_i) state_d = WAIT1_3;
            end
            WAIT1_3: begin
                if (!sw_i)        state_d = ZERO;
                else if (m_tick_i) state_d = ONE;
            end
            ONE: begin
                if (!sw_i) state_d = WAIT0_1;
            end
            WAIT0_1: begin
                if (sw_i)          state_d = ONE;
                else if (m_tick_i) state_d = WAIT0_2;
            end
            WAIT0_2: begin
                if (sw_i)          state_d = ONE;
                else if (m_tick_i) state_d = WAIT0_3;
            end
            WAIT0_3: begin
                if (sw_i)          state_d = ONE;
                else if (m_tick_i) state_d = ZERO;
            end
            default: state_d = ZERO;
        endcase
    end

    // Output level is decoded from the next state and registered, so db_o
    // always equals the decode of the current state with no input path.
    always_comb begin
        db_d = db_level(state_d);
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ZERO;
            db_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            db_q    <= db_d;
        end
    end

    assign db_o = db_q;

`ifdef DEBOUNCE_EDGE_TICK_EN
    logic db_tick_q;
    logic db_tick_d;

    // Pulse only on the confirming tick that moves WAIT1_3 into ONE.
    always_comb begin
        db_tick_d = (state_q == WAIT1_3) && sw_i && m_tick_i;
    end

    // Edge pulse register with asynchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) db_tick_q <= 1'b0;
        else       db_tick_q <= db_tick_d;
    end

    assign db_tick_o = db_tick_q;
`endif

endmodule

// File: tb/tb_debouncing_circuito.sv
// Scoreboard bench for debouncing_circuito: directed vectors push expected
// state/outputs into a queue; a monitor pops and compares after each edge.
module tb_debouncing_circuito;
    import debouncing_pkg::*;

    logic clk;
    logic rst;
    logic sw;
    logic tick;
    logic db;
    logic db_tick;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int     cyc;
        state_t st;
        logic   db;
        logic   tk;
        string  tag;
    } exp_t;

    exp_t exp_q[$];

    debouncing_circuito dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .sw_i     (sw),
        .m_tick_i (tick),
        .db_o     (db)
`ifdef DEBOUNCE_EDGE_TICK_EN
        ,
        .db_tick_o(db_tick)
`endif
    );

`ifndef DEBOUNCE_EDGE_TICK_EN
    assign db_tick = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Compare the DUT against an expectation, counting into the shared totals.
    task automatic compare(input string tag, input state_t est, input logic edb, input logic etk);
        checks++;
        if (dut.state !== est || db !== edb
`ifdef DEBOUNCE_EDGE_TICK_EN
            || db_tick !== etk
`endif
        ) begin
            errors++;
            $display("FAIL %s: got state=%s db=%b tick=%b, expected state=%s db=%b tick=%b",
                     tag, dut.state.name(), db, db_tick, est.name(), edb, etk);
        end
    endtask

    // Drive one cycle of inputs and queue the state expected after the next edge.
    task automatic step(input string tag, input logic s, input logic t,
                        input state_t est, input logic edb, input logic etk);
        exp_t e;
        sw   = s;
        tick = t;
        e.cyc = cyc + 1;
        e.st  = est;
        e.db  = edb;
        e.tk  = etk;
        e.tag = tag;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Monitor: after every edge, retire expectations that target this cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                e = exp_q.pop_front();
                compare(e.tag, e.st, e.db, e.tk);
            end
        end
    end

    initial begin
        rst  = 1'b1;
        sw   = 1'b0;
        tick = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        compare("reset", ZERO, 1'b0, 1'b0);
        rst = 1'b0;

        step("idle",      1'b0, 1'b0, ZERO,    1'b0, 1'b0);

        // Clean press, ticks two cycles apart
        step("press_w1",  1'b1, 1'b0, WAIT1_1, 1'b0, 1'b0);
        step("press_h1",  1'b1, 1'b0, WAIT1_1, 1'b0, 1'b0);
        step("press_w2",  1'b1, 1'b1, WAIT1_2, 1'b0, 1'b0);
        step("press_h2",  1'b1, 1'b0, WAIT1_2, 1'b0, 1'b0);
        step("press_w3",  1'b1, 1'b1, WAIT1_3, 1'b0, 1'b0);
        step("press_h3",  1'b1, 1'b0, WAIT1_3, 1'b0, 1'b0);
        step("press_one", 1'b1, 1'b1, ONE,     1'b1, 1'b1);
        step("press_end", 1'b1, 1'b0, ONE,     1'b1, 1'b0);
        step("one_tick",  1'b1, 1'b1, ONE,     1'b1, 1'b0);

        // Clean release
        step("rel_w1",    1'b0, 1'b0, WAIT0_1, 1'b1, 1'b0);
        step("rel_w2",    1'b0, 1'b1, WAIT0_2, 1'b1, 1'b0);
        step("rel_h2",    1'b0, 1'b0, WAIT0_2, 1'b1, 1'b0);
        step("rel_w3",    1'b0, 1'b1, WAIT0_3, 1'b1, 1'b0);
        step("rel_h3",    1'b0, 1'b0, WAIT0_3, 1'b1, 1'b0);
        step("rel_zero",  1'b0, 1'b1, ZERO,    1'b0, 1'b0);
        step("rel_idle",  1'b0, 1'b0, ZERO,    1'b0, 1'b0);

        // Bounce after one tick
        step("bnc_w1",    1'b1, 1'b0, WAIT1_1, 1'b0, 1'b0);
        step("bnc_w2",    1'b1, 1'b1, WAIT1_2, 1'b0, 1'b0);
        step("bnc_zero",  1'b0, 1'b0, ZERO,    1'b0, 1'b0);

        // Bounce and tick together: bounce wins
        step("pri_w1",    1'b1, 1'b0, WAIT1_1, 1'b0, 1'b0);
        step("pri_w2",    1'b1, 1'b1, WAIT1_2, 1'b0, 1'b0);
        step("pri_zero",  1'b0, 1'b1, ZERO,    1'b0, 1'b0);

        // Tick held high counts every cycle; ZERO->WAIT1_1 consumes no tick
        step("hold_w1",   1'b1, 1'b1, WAIT1_1, 1'b0, 1'b0);
        step("hold_w2",   1'b1, 1'b1, WAIT1_2, 1'b0, 1'b0);
        step("hold_w3",   1'b1, 1'b1, WAIT1_3, 1'b0, 1'b0);
        step("hold_one",  1'b1, 1'b1, ONE,     1'b1, 1'b1);
        step("hold_stay", 1'b1, 1'b1, ONE,     1'b1, 1'b0);

        // Release bounce back to ONE: no edge pulse
        step("rb_w1",     1'b0, 1'b1, WAIT0_1, 1'b1, 1'b0);
        step("rb_w2",     1'b0, 1'b1, WAIT0_2, 1'b1, 1'b0);
        step("rb_one",    1'b1, 1'b1, ONE,     1'b1, 1'b0);
        step("rb2_w1",    1'b0, 1'b1, WAIT0_1, 1'b1, 1'b0);
        step("rb2_w2",    1'b0, 1'b1, WAIT0_2, 1'b1, 1'b0);
        step("rb2_w3",    1'b0, 1'b1, WAIT0_3, 1'b1, 1'b0);
        step("rb3_one",   1'b1, 1'b1, ONE,     1'b1, 1'b0);
        step("rel2_w1",   1'b0, 1'b0, WAIT0_1, 1'b1, 1'b0);
        step("rel2_w2",   1'b0, 1'b1, WAIT0_2, 1'b1, 1'b0);
        step("rel2_w3",   1'b0, 1'b1, WAIT0_3, 1'b1, 1'b0);
        step("rel2_zero", 1'b0, 1'b1, ZERO,    1'b0, 1'b0);

        // Async reset while in WAIT1_3, asserted between clock edges
        step("ar_w1",     1'b1, 1'b0, WAIT1_1, 1'b0, 1'b0);
        step("ar_w2",     1'b1, 1'b1, WAIT1_2, 1'b0, 1'b0);
        step("ar_w3",     1'b1, 1'b1, WAIT1_3, 1'b0, 1'b0);
        tick = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        compare("async_rst", ZERO, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step("post_rst",  1'b1, 1'b0, WAIT1_1, 1'b0, 1'b0);
        step("post_idle", 1'b0, 1'b0, ZERO,    1'b0, 1'b0);

        @(posedge clk);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: simulation still running at %0t, expected finish", $time);
        $fatal(1);
    end

endmodule
